// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: arbitrates two requesters onto one shared add/sub datapath and returns tagged results.
// Define ALU_SHARE_RR_EN for round-robin arbitration; fixed priority (requester 0 wins) otherwise.
module alu_share_ctrl #(
  parameter int BITS     = 8,
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [BITS-1:0]     req0_a,
  input  logic [BITS-1:0]     req0_b,
  input  logic                req0_s,
  input  logic [BITS-1:0]     req1_a,
  input  logic [BITS-1:0]     req1_b,
  input  logic                req1_s,
  output logic [BITS-1:0]     alu_ra,
  output logic [BITS-1:0]     alu_rb,
  output logic                alu_s,
  input  logic [BITS-1:0]     alu_out,
  input  logic                alu_carry,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [BITS-1:0]     rsp_data,
  output logic                rsp_flag,
  output logic [CNT_BITS-1:0] ops_count
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t                r_state, w_next;
  logic [BITS-1:0]       r_a, r_b, r_data;
  logic                  r_s, r_id, r_flag;
  logic [CNT_BITS-1:0]   r_cnt;
  logic                  w_g, w_hs, w_done;
`ifdef ALU_SHARE_RR_EN
  logic r_ptr;
  always_ff @(posedge clk)
    if (rst) r_ptr <= 1'b0;
    else if (w_done) r_ptr <= ~r_id;
  assign w_g = req_valid[r_ptr] ? r_ptr : ~r_ptr;
`else
  assign w_g = ~req_valid[0];
`endif
  assign w_hs      = r_state == IDLE && |req_valid;
  assign w_done    = r_state == RESP && rsp_ready;
  assign req_ready = w_hs ? {w_g, ~w_g} : 2'b00;
  always_comb begin
    w_next = r_state;
    if (w_hs) w_next = EXEC;
    else if (r_state == EXEC) w_next = RESP;
    else if (w_done) w_next = IDLE;
  end
  // The datapath carry is meaningless for subtract, so the borrow is derived from the operands.
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= 1'b0;
      r_id    <= 1'b0;
      r_data  <= '0;
      r_flag  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_hs) begin
        r_a  <= w_g ? req1_a : req0_a;
        r_b  <= w_g ? req1_b : req0_b;
        r_s  <= w_g ? req1_s : req0_s;
        r_id <= w_g;
      end
      if (r_state == EXEC) begin
        r_data <= alu_out;
        r_flag <= r_s ? r_a < r_b : alu_carry;
      end
      if (w_done) r_cnt <= r_cnt + 1'b1;
    end
  assign alu_ra    = r_a;
  assign alu_rb    = r_b;
  assign alu_s     = r_s;
  assign rsp_valid = r_state == RESP;
  assign rsp_id    = r_id;
  assign rsp_data  = r_data;
  assign rsp_flag  = r_flag;
  assign ops_count = r_cnt;
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: randomized scoreboard bench with a behavioural add/sub and arbitration model.
module tb_alu_share_ctrl;
  localparam int W  = 8;
  localparam int CW = 4;
  typedef struct packed {logic [W-1:0] a; logic [W-1:0] b; logic s;} op_t;
  typedef struct packed {logic id; logic [W-1:0] d; logic f;} rsp_t;
  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req_valid, req_ready;
  logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
  logic          req0_s, req1_s;
  logic [W-1:0]  alu_ra, alu_rb, alu_out;
  logic          alu_s, alu_carry;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_flag;
  logic [W-1:0]  rsp_data;
  logic [CW-1:0] ops_count;
  op_t           p0[$], p1[$];
  rsp_t          q[$], got[$];
  bit            m_idle = 1'b1, m_ptr = 1'b0, rel = 1'b0, chk_en = 1'b0, m_sid = 1'b0, ev;
  logic [CW-1:0] m_cnt = '0;
  int            cyc = 0, due = 0, n_cmp = 0, n_bad = 0, bp = 0, rdy_mode = 1;

  always #5 clk = ~clk;

  alu_share_ctrl #(.BITS(W), .CNT_BITS(CW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_s(req0_s),
    .req1_a(req1_a), .req1_b(req1_b), .req1_s(req1_s),
    .alu_ra(alu_ra), .alu_rb(alu_rb), .alu_s(alu_s), .alu_out(alu_out), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_flag(rsp_flag), .ops_count(ops_count)
  );

  always_comb {alu_carry, alu_out} = alu_s ? {1'b0, alu_ra - alu_rb} : {1'b0, alu_ra} + {1'b0, alu_rb};

  function automatic rsp_t ref_op(input bit id, input op_t o);
    rsp_t        r;
    int unsigned x, y;
    x    = 32'(o.a);
    y    = 32'(o.b);
    r.id = id;
    if (o.s) begin
      r.d = W'(x + 256 - y);
      r.f = x < y;
    end else begin
      r.d = W'(x + y);
      r.f = (x + y) > 255;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] g, input logic [31:0] e);
    n_cmp++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, g, e, $time);
    end
  endtask

  function automatic op_t rnd_op();
    op_t o;
    o.a = W'($urandom);
    o.b = W'($urandom);
    o.s = 1'($urandom);
    return o;
  endfunction

  task automatic drive();
    op_t o0, o1;
    o0        = p0.size() > 0 ? p0[0] : rnd_op();
    o1        = p1.size() > 0 ? p1[0] : rnd_op();
    req_valid = {p1.size() > 0, p0.size() > 0};
    {req0_a, req0_b, req0_s} = o0;
    {req1_a, req1_b, req1_s} = o1;
    rsp_ready = rdy_mode == 1 ? 1'b1 : rdy_mode == 2 ? (bp == 0) : ($urandom_range(0, 3) != 0);
    if (rdy_mode == 2 && rsp_valid && bp > 0) bp--;
  endtask

  task automatic step();
    logic [1:0] er;
    bit         g;
    op_t        o;
    g = 1'b0;
    @(negedge clk);
    er = 2'b00;
    if (m_idle && req_valid != 2'b00) begin
`ifdef ALU_SHARE_RR_EN
      g = (req_valid == 2'b11) ? m_ptr : req_valid[1];
`else
      g = req_valid[0] ? 1'b0 : 1'b1;
`endif
      er[g] = 1'b1;
    end
    if (chk_en) chk("req_ready", 32'(req_ready), 32'(er));
    if (er != 2'b00) begin
      o = g ? p1.pop_front() : p0.pop_front();
      q.push_back(ref_op(g, o));
      m_idle = 1'b0;
      due    = cyc + 2;
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((p0.size() > 0 || p1.size() > 0 || q.size() > 0 || !m_idle) && k < 300) begin
      step();
      k++;
    end
    if (k >= 300) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got busy expected idle within 300 cycles");
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      q.delete();
      m_idle = 1'b1;
      m_ptr  = 1'b0;
      m_cnt  = '0;
      rel    = 1'b0;
    end else if (rel) begin
      rel    = 1'b0;
      m_idle = 1'b1;
      m_cnt  = m_cnt + 1'b1;
      m_ptr  = ~m_sid;
    end
  end

  always @(negedge clk)
    if (chk_en && !rst) begin
      ev = q.size() > 0 && cyc >= due;
      chk("rsp_valid", 32'(rsp_valid), 32'(ev));
      if (rsp_valid && ev) begin
        chk("rsp", 32'({rsp_id, rsp_data, rsp_flag}), 32'(q[0]));
        if (rsp_ready) begin
          got.push_back({rsp_id, rsp_data, rsp_flag});
          m_sid = q[0].id;
          void'(q.pop_front());
          rel = 1'b1;
        end
      end
      chk("ops_count", 32'(ops_count), 32'(m_cnt));
    end

  task automatic chk_reset_vals();
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_alu_ra", 32'(alu_ra), 0);
    chk("rst_alu_rb", 32'(alu_rb), 0);
    chk("rst_alu_s", 32'(alu_s), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_rsp_flag", 32'(rsp_flag), 0);
    chk("rst_ops_count", 32'(ops_count), 0);
  endtask

  initial begin
    int k;
    bit e;
    rst = 1'b1;
    p0.delete();
    p1.delete();
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_vals();
    @(posedge clk);
    #1;
    rst    = 1'b0;
    chk_en = 1'b1;
    p0.push_back('{8'hF0, 8'h20, 1'b0});
    drive();
    drain();
    chk("add_rsp", 32'(got[0]), 32'(rsp_t'{1'b0, 8'h10, 1'b1}));
    chk("add_count", 32'(ops_count), 1);
    p1.push_back('{8'h05, 8'h07, 1'b1});
    drive();
    drain();
    chk("sub_borrow", 32'(got[1]), 32'(rsp_t'{1'b1, 8'hFE, 1'b1}));
    p1.push_back('{8'h07, 8'h05, 1'b1});
    drive();
    drain();
    chk("sub_noborrow", 32'(got[2]), 32'(rsp_t'{1'b1, 8'h02, 1'b0}));
    rdy_mode = 2;
    bp       = 5;
    p0.push_back(rnd_op());
    drive();
    drain();
    chk("bp_count", 32'(ops_count), 4);
    rdy_mode = 1;
    p0.push_back(rnd_op());
    drive();
    k = 0;
    while (m_idle && k < 20) begin
      step();
      k++;
    end
    chk("mid_handshake", 32'(m_idle), 0);
    chk_en = 1'b0;
    rst    = 1'b1;
    p0.delete();
    drive();
    @(posedge clk);
    #1;
    @(negedge clk);
    chk_reset_vals();
    @(posedge clk);
    #1;
    rst    = 1'b0;
    chk_en = 1'b1;
    repeat (5) step();
    got.delete();
    repeat (6) begin
      p0.push_back(rnd_op());
      p1.push_back(rnd_op());
    end
    drive();
    drain();
    for (int i = 0; i < 6; i++) begin
`ifdef ALU_SHARE_RR_EN
      e = 1'(i % 2);
`else
      e = 1'b0;
`endif
      chk("contention_id", 32'(got[i].id), 32'(e));
    end
    rdy_mode = 0;
    repeat (400) begin
      if ($urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 1) == 0) begin
          if (p0.size() < 3) p0.push_back(rnd_op());
        end else if (p1.size() < 3) p1.push_back(rnd_op());
      end
      step();
    end
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end
endmodule
